// File: rtl/issue_queue.sv
// issue_queue: in-order circular issue buffer with show-ahead read port.
// Occupancy is tracked by an explicit counter so full/empty never depend on
// pointer aliasing; storage is never cleared, only the pointers and counter.
module issue_queue #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push_front,
    input  logic [WIDTH-1:0]           din,
    output logic                       full,
    output logic                       almost_full,
    input  logic                       pop_back,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    occ;
    logic             push_ok;
    logic             pop_ok;

    // Status flags come straight from the occupancy register.
    assign count       = occ;
    assign empty       = (occ == '0);
    assign full        = (occ == CW'(DEPTH));
    assign almost_full = (occ >= CW'(AF_LEVEL));

    // Accept decisions and show-ahead output; a pop frees a slot so a push
    // into a full queue still goes through when paired with a pop.
    always_comb begin
        pop_ok  = pop_back && !empty;
        push_ok = push_front && (!full || pop_back);
        dout    = empty ? '0 : mem[rd_ptr];
    end

    // Pointer, occupancy and error-pulse state; reset outranks flush.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occ       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= push_front && full && !pop_back;
            underflow <= pop_back && empty;
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_ok && !pop_ok) begin
                occ <= occ + CW'(1);
            end else if (pop_ok && !push_ok) begin
                occ <= occ - CW'(1);
            end
        end
    end

    // Payload storage; a slot written during reset/flush is never exposed
    // because the counter is cleared in the same edge.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning payload bits per entry.
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of entries; legal values are powers of two, 2 to 64.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-1, meaning the occupancy at or above which almost_full asserts; legal values are 1 to DEPTH.
REQ-004 SHALL have the following ports:
- clk  input  1  sole clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous discard of all entries (pipeline redirect).
- push_front  input  1  request to enqueue din.
- din  input  WIDTH  enqueue payload.
- full  output  1  occupancy == DEPTH.
- almost_full  output  1  occupancy >= AF_LEVEL.
- pop_back  input  1  request to dequeue the oldest entry.
- dout  output  WIDTH  oldest entry (show-ahead).
- empty  output  1  occupancy == 0.
- count  output  $clog2(DEPTH+1)  current occupancy.
- overflow  output  1  one-cycle pulse: a push was dropped.
- underflow  output  1  one-cycle pulse: a pop was ignored.

Function
REQ-005 SHALL implement a circular buffer with read pointer, write pointer and occupancy counter; entries leave in arrival order.
REQ-006 SHALL present the entry at the read pointer on dout combinationally whenever empty is low; dout SHALL be all-zero whenever empty is high.
REQ-007 SHALL drive full, almost_full, empty and count from registered state only, with no combinational path from any input.
REQ-008 SHALL accept a push when push_front=1 and either full=0, or pop_back=1 in the same cycle; an accepted push writes din at the write pointer and advances the pointer.
REQ-009 SHALL accept a pop when pop_back=1 and empty=0; an accepted pop advances the read pointer, and the next entry appears on dout the following cycle.
REQ-010 SHALL, on an accepted push and pop in the same cycle, leave count unchanged and move both pointers; this holds also when full=1.
REQ-011 SHALL, on push_front=1 and pop_back=1 while empty=1, accept the push and ignore the pop (no fall-through); count becomes 1 and underflow pulses.
REQ-012 SHALL wrap each pointer from DEPTH-1 to 0 with no bubble.
REQ-013 SHALL pulse overflow for exactly one cycle, the cycle after a push is dropped (push_front=1, full=1, pop_back=0); stored contents SHALL be unchanged.
REQ-014 SHALL pulse underflow for exactly one cycle, the cycle after a pop_back=1 while empty=1; state SHALL be unchanged apart from any accepted push.
REQ-015 SHALL treat flush=1 as follows: in the next cycle count=0, empty=1, full=0, almost_full=0, both pointers=0. A push or pop in the same cycle is discarded, and overflow/underflow SHALL not pulse for that cycle.
REQ-016 SHALL give a stored entry a latency of exactly one cycle from push to visibility on dout when the queue was empty.
REQ-017 SHALL keep count in the range 0 to DEPTH at all times, with no arithmetic wrap of count.
REQ-018 SHALL not reset or clear storage contents; correctness depends only on the pointers and the counter.

Reset
REQ-019 SHALL, on rst=1 at a clock edge, set count=0, empty=1, full=0, both pointers=0, overflow=0, underflow=0; almost_full SHALL be 0 for AF_LEVEL>=1.
REQ-020 SHALL give rst priority over flush, push and pop; reset mid-operation discards all entries identically to flush.
REQ-021 SHALL drive dout=0 for as long as rst is held and until the first accepted push.

Verification
REQ-022 Fill/drain (DEPTH=4): push 0xA,0xB,0xC,0xD -> full=1, count=4, almost_full=1 from count=3; then pop ×4 -> dout reads 0xA,0xB,0xC,0xD in order, then empty=1 and dout=0.
REQ-023 Overflow: with the queue full, push 0xE with no pop -> overflow pulses for 1 cycle, count stays 4, subsequent pops return 0xA..0xD.
REQ-024 Simultaneous at full: with the queue full of 0xA..0xD, push 0xE with a pop in the same cycle -> count=4, dout=0xB next cycle, 0xE is returned last.
REQ-025 Empty push+pop: with the queue empty, push 0x5 with a pop in the same cycle -> count=1, dout=0x5 next cycle, underflow pulses once.
REQ-026 Wrap: run 10 alternating push/pop pairs of values 1..10 through DEPTH=4 -> every value pops in order with no loss; pointers wrap at least twice.
REQ-027 Flush/reset mid-stream: with count=3, assert flush together with a push of 0x9 -> next cycle empty=1, count=0, no overflow, and 0x9 is never output; repeat the test with rst instead of flush and require the same result.
